sport_tx: RTL

- Upstream SPORT transmitter feeding the 4-bit SPORT receiver.
- Accepts 32-bit words from the local side over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each word MSB-nibble-first onto a 4-bit data bus framed by active-low FS, one nibble per sport_clk cycle.
- Inserts a programmable FS-high gap between frames.

---
 rtl/sport_tx.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sport_tx.sv
// rtl/sport_tx.sv - SPORT transmitter: word FIFO, MSB-nibble-first serialiser framed by active-low FS
module sport_tx #(
    parameter int WORD_W     = 32,
    parameter int LANE_W     = 4,
    parameter int GAP_CYCLES = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              sport_clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              FS,
    output logic [LANE_W-1:0] data,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);

    localparam int NIBBLES = WORD_W / LANE_W;
    localparam int NIB_W   = $clog2(NIBBLES + 1);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIBBLES);
    localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_next;
    logic [WORD_W-1:0] head;
    logic              push, pop, can_start, gap_done;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [NIB_W-1:0]  nib_cnt;
    logic [3:0]        gap_cnt;

    assign push      = in_valid & in_ready;
    assign can_start = tx_en && (count != '0);
    assign gap_done  = (gap_cnt == GAP_LAST);
    // A frame may only be launched from IDLE or from the last gap cycle.
    assign pop       = can_start && ((state == IDLE) || ((state == GAP) && gap_done));
    assign head      = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_W'(1);
        else if (!push && pop)
            count_next = count - CNT_W'(1);
    end

    always_ff @(negedge sport_clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(negedge sport_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_next;
            in_ready <= (count_next != FULL_CNT);
        end
    end

    always_ff @(negedge sport_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            FS         <= 1'b1;
            data       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            shreg      <= '0;
            nib_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (pop) begin
                FS      <= 1'b0;
                data    <= head[WORD_W-1 -: LANE_W];
                shreg   <= head << LANE_W;
                nib_cnt <= NIB_W'(1);
                busy    <= 1'b1;
                state   <= SHIFT;
            end else begin
                case (state)
                    SHIFT: begin
                        if (nib_cnt == NIB_LAST) begin
                            FS         <= 1'b1;
                            data       <= '0;
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                            gap_cnt    <= 4'd1;
                            state      <= GAP;
                        end else begin
                            data    <= shreg[WORD_W-1 -: LANE_W];
                            shreg   <= shreg << LANE_W;
                            nib_cnt <= nib_cnt + NIB_W'(1);
                        end
                    end
                    GAP: begin
                        if (gap_done) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
